// File: rtl/sisc_ctrl_mc.sv
// -----------------------------------------------------------------------------
// sisc_ctrl_mc -- multi-cycle SISC control unit
//
// Purpose:
//   Sequences each instruction through FETCH/DECODE/EXEC and, when needed,
//   MEM/WB/WB2. It stalls in MEM until data memory reports done, and parks in
//   HALT on the halt opcode until the next reset. Outputs are Moore-style,
//   decoded from the registered state plus the opcode/mm/stat fields.
//
// Optional feature (macro CTRL_PERF_EN):
//   Adds a retired-instruction counter on output instr_cnt[CNT_W-1:0].
//
// Ports:
//   clk       in   system clock, all state updates on posedge
//   rst_f     in   synchronous active-low reset
//   opcode    in   instruction opcode field
//   mm        in   mode/mask field
//   stat      in   status flags
//   mem_rdy   in   data memory done
//   pc_rst    out  force PC to 0
//   pc_write  out  PC load enable
//   pc_sel    out  0: PC+1, 1: branch address
//   br_sel    out  0: PC-relative, 1: absolute
//   ir_load   out  IR load enable
//   rf_we     out  register-file write enable
//   wb_sel    out  0: ALU result, 1: memory data
//   rb_sel    out  read-port B select (0: rt, 1: rd)
//   dm_we     out  data-memory write enable
//   mem_req   out  data-memory access request
//   alu_op    out  00 reg-reg, 01 reg-imm, 10 pass/no-op
//   halted    out  1 while in HALT
//   instr_cnt out  retired-instruction count (CTRL_PERF_EN only)
// -----------------------------------------------------------------------------
module sisc_ctrl_mc #(
    parameter int OPW    = 4,
    parameter int STAT_W = 4,
    parameter int HLT_OP = 15,
    parameter int IMM_MM = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic [OPW-1:0]    opcode,
    input  logic [STAT_W-1:0] mm,
    input  logic [STAT_W-1:0] stat,
    input  logic              mem_rdy,
    output logic              pc_rst,
    output logic              pc_write,
    output logic              pc_sel,
    output logic              br_sel,
    output logic              ir_load,
    output logic              rf_we,
    output logic              wb_sel,
    output logic              rb_sel,
    output logic              dm_we,
    output logic              mem_req,
    output logic [1:0]        alu_op,
    output logic              halted
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]  instr_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_WB2    = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    localparam logic [OPW-1:0]    OP_NOOP = OPW'(0);
    localparam logic [OPW-1:0]    OP_LOD  = OPW'(1);
    localparam logic [OPW-1:0]    OP_STR  = OPW'(2);
    localparam logic [OPW-1:0]    OP_SWP  = OPW'(3);
    localparam logic [OPW-1:0]    OP_BRA  = OPW'(4);
    localparam logic [OPW-1:0]    OP_BRR  = OPW'(5);
    localparam logic [OPW-1:0]    OP_BNE  = OPW'(6);
    localparam logic [OPW-1:0]    OP_BNR  = OPW'(7);
    localparam logic [OPW-1:0]    OP_ALU  = OPW'(8);
    localparam logic [OPW-1:0]    OP_HLT  = OPW'(HLT_OP);
    localparam logic [STAT_W-1:0] MM_IMM  = STAT_W'(IMM_MM);

    state_t state_r;
    state_t state_next_s;
    logic   br_hit_s;
    logic   use_imm_s;

    // Any status bit selected by the mask.
    assign br_hit_s  = |(stat & mm);
    assign use_imm_s = (mm == MM_IMM);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_r <= ST_RST;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_next_s = state_r;
        pc_rst       = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        br_sel       = 1'b0;
        ir_load      = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 1'b0;
        rb_sel       = 1'b0;
        dm_we        = 1'b0;
        mem_req      = 1'b0;
        alu_op       = 2'b10;
        halted       = 1'b0;
        case (state_r)
            ST_RST: begin
                pc_rst       = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_FETCH: begin
                ir_load      = 1'b1;
                pc_write     = 1'b1;
                state_next_s = ST_DECODE;
            end
            ST_DECODE: begin
                // Opcodes 0..8 and the halt opcode are defined; the rest act as NOOP.
                if (opcode == OP_HLT) begin
                    state_next_s = ST_HALT;
                end else if ((opcode == OP_NOOP) || (opcode > OP_ALU)) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next_s = ST_FETCH;
                case (opcode)
                    OP_ALU, OP_SWP: begin
                        alu_op       = use_imm_s ? 2'b01 : 2'b00;
                        state_next_s = ST_WB;
                    end
                    OP_LOD, OP_STR: begin
                        alu_op       = use_imm_s ? 2'b01 : 2'b00;
                        state_next_s = ST_MEM;
                    end
                    OP_BRA, OP_BRR: begin
                        pc_write = br_hit_s;
                        pc_sel   = br_hit_s;
                        br_sel   = br_hit_s && (opcode == OP_BRA);
                    end
                    OP_BNE, OP_BNR: begin
                        pc_write = !br_hit_s;
                        pc_sel   = !br_hit_s;
                        br_sel   = !br_hit_s && (opcode == OP_BNE);
                    end
                    default: begin
                        state_next_s = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                if (opcode == OP_STR) begin
                    rb_sel = 1'b1;
                    dm_we  = 1'b1;
                end else begin
                    rb_sel = 1'b0;
                end
                // Unbounded stall: memory is trusted to answer eventually.
                if (!mem_rdy) begin
                    state_next_s = ST_MEM;
                end else if (opcode == OP_STR) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_WB;
                end
            end
            ST_WB: begin
                rf_we  = 1'b1;
                wb_sel = (opcode == OP_LOD);
                if (opcode == OP_SWP) begin
                    state_next_s = ST_WB2;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_WB2: begin
                rf_we        = 1'b1;
                rb_sel       = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_HALT: begin
                halted       = 1'b1;
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_RST;
            end
        endcase
    end

`ifdef CTRL_PERF_EN
    // Retired-instruction counter: each FETCH entry after the first retires one.
    always_ff @(posedge clk) begin
        if (!rst_f || (state_r == ST_RST)) begin
            instr_cnt <= {CNT_W{1'b0}};
        end else if (state_next_s == ST_FETCH) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end else begin
            instr_cnt <= instr_cnt;
        end
    end
`endif

endmodule
